lp_decim_quant: RTL

Post-filter stage directly downstream of the low-pass FIR. It takes the FIR's full-precision output stream, keeps one sample in every DECIM, and reduces the width with round-half-up and saturation. Results are buffered in a small FIFO that drives an AXI-stream master with backpressure. The FIR has no tready, so this block absorbs backpressure: it drops samples on overflow and flags the event.

---
 rtl/lp_chain_pkg.sv | 45 ++++
 rtl/stream_fifo.sv | 56 +++++
 rtl/lp_decim_quant.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lp_chain_pkg.sv
// Shared definitions for the low-pass chain: default widths, the
// round/saturate helper and the FIFO level-width calculation.
package lp_chain_pkg;

  // Default widths shared with the FIR
  localparam int unsigned LpIw    = 24;
  localparam int unsigned LpOw    = 16;
  localparam int unsigned LpShift = 8;

  typedef struct packed {
    logic        sat;
    logic [63:0] data;
  } rnd_sat_t;

  // Occupancy needs one more bit than the address so that "full" is representable
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Arithmetic right shift of an already-biased value, then clamp to a signed
  // ow-bit range. Data comes back sign-extended to 64 bits; callers keep the
  // low ow bits.
  function automatic rnd_sat_t shift_sat(input logic signed [63:0] r,
                                         input int unsigned        shift,
                                         input int unsigned        ow);
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd_sat_t           res;
    y        = r >>> shift;
    hi       = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (ow - 1));
    res.sat  = 1'b0;
    res.data = y;
    if (y > hi) begin
      res.sat  = 1'b1;
      res.data = hi;
    end else if (y < lo) begin
      res.sat  = 1'b1;
      res.data = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra bit so
// full and empty are told apart without a separate counter.
module stream_fifo
  import lp_chain_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [Width-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [Width-1:0]            rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [level_w(Depth)-1:0]   level
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wptr_q;
  logic [Aw:0]      rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_wr;
  logic             do_rd;

  // Status flags and handshake qualification
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    do_rd = rd_en & ~empty;
    // A write into a full FIFO only lands if a read frees a slot this cycle
    do_wr = wr_en & (~full | do_rd);
    level = wptr_q - rptr_q;
    // Head is presented directly; zero when empty so idle output is defined
    rd_data = empty ? '0 : mem_q[rptr_q[Aw-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array, no reset needed since empty masks the output
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[Aw-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lp_decim_quant.sv
// Post-FIR decimator and quantiser: keeps one sample in DECIM, rounds half
// up, saturates to OW bits and buffers into an AXI-stream FIFO. The FIR cannot
// be stalled, so FIFO overflow drops the sample and raises a sticky flag.
module lp_decim_quant
  import lp_chain_pkg::*;
#(
  parameter int unsigned IW    = LpIw,
  parameter int unsigned OW    = LpOw,
  parameter int unsigned SHIFT = LpShift,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [IW-1:0]               s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        sync_clr,
  input  logic                        flags_clr,
  output logic [OW-1:0]               m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [level_w(DEPTH)-1:0]   fifo_level,
  output logic                        sat_sticky,
  output logic                        ovf_sticky
);

  localparam int unsigned       PW        = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0]     PhaseLast = PW'(DECIM - 1);
  localparam logic signed [IW:0] RoundK   = {{IW{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [PW-1:0]      phase_q;
  logic [PW-1:0]      phase_d;
  logic               keep;
  logic signed [IW:0] s1_r_q;
  logic               s1_v_q;
  rnd_sat_t           rs;
  logic               rs_unused;
  logic [OW-1:0]      s2_d_q;
  logic               s2_sat_q;
  logic               s2_v_q;
  logic               fifo_empty;
  logic               fifo_full;
  logic               sat_set;
  logic               ovf_set;
  logic               sat_q;
  logic               ovf_q;

  // Phase tracking; sync_clr forces the current sample to phase 0
  always_comb begin
    keep    = s_axis_tvalid & (sync_clr | (phase_q == '0));
    phase_d = phase_q;
    if (sync_clr) begin
      phase_d = (s_axis_tvalid && (DECIM > 1)) ? PW'(1) : '0;
    end else if (s_axis_tvalid) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
    end
  end

  // Phase register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  // Stage 1: add the rounding bias one bit wider so it cannot wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q <= 1'b0;
      s1_r_q <= '0;
    end else begin
      s1_v_q <= keep;
      if (keep) s1_r_q <= $signed({s_axis_tdata[IW-1], s_axis_tdata}) + RoundK;
    end
  end

  // Stage 2 combinational shift and clamp
  always_comb begin
    rs        = shift_sat(64'(s1_r_q), SHIFT, OW);
    rs_unused = ^rs.data[63:OW];
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v_q   <= 1'b0;
      s2_d_q   <= '0;
      s2_sat_q <= 1'b0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_d_q   <= rs.data[OW-1:0];
        s2_sat_q <= rs.sat;
      end
    end
  end

  stream_fifo #(
    .Width (OW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (s2_v_q),
    .wr_data (s2_d_q),
    .rd_en   (m_axis_tready),
    .rd_data (m_axis_tdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  // Sticky set conditions; a full FIFO is never empty so tready alone decides the read
  always_comb begin
    m_axis_tvalid = ~fifo_empty;
    sat_set       = s2_v_q & s2_sat_q;
    ovf_set       = s2_v_q & fifo_full & ~m_axis_tready;
    sat_sticky    = sat_q;
    ovf_sticky    = ovf_q;
  end

  // Sticky flags; set has priority over clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_set | (sat_q & ~flags_clr);
      ovf_q <= ovf_set | (ovf_q & ~flags_clr);
    end
  end

endmodule
